// File: rtl/decode_stage.sv
// decode_stage: instruction decode for the 8-bit pipeline (hold, scoreboard, JMP/BEQZ, HALT).
// Ports: fetch in (if_*), fetch ctrl out (stall/flush/PC_sel/branch_target/halt),
//   rf read (rf_*), writeback (wb_*), execute issue (ex_*). Option: DECODE_WB_BYPASS_EN.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] if_instruction,
    input  logic [7:0]  if_pc,
    input  logic        if_valid,
    output logic        stall,
    output logic        flush,
    output logic        PC_sel,
    output logic [7:0]  branch_target,
    output logic        halt,
    output logic [2:0]  rf_raddr1,
    output logic [2:0]  rf_raddr2,
    input  logic [7:0]  rf_rdata1,
    input  logic [7:0]  rf_rdata2,
    input  logic        wb_valid,
    input  logic [2:0]  wb_rd,
    input  logic [7:0]  wb_data,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [3:0]  ex_opcode,
    output logic [2:0]  ex_rd,
    output logic [7:0]  ex_a,
    output logic [7:0]  ex_b,
    output logic [7:0]  ex_imm,
    output logic [7:0]  ex_pc
);

    typedef enum logic [1:0] {S_RUN, S_HOLD, S_HALTED} state_e;

    state_e      state_q, state_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [7:0]  hold_pc_q, hold_pc_d;
    logic [7:0]  sb_q, sb_d;
    logic        halt_q, halt_d;
    logic        exv_q, exv_d, exrw_q, exrw_d;
    logic        exmr_q, exmr_d, exmw_q, exmw_d;
    logic [3:0]  exop_q, exop_d;
    logic [2:0]  exrd_q, exrd_d;
    logic [7:0]  exa_q, exa_d, exb_q, exb_d;
    logic [7:0]  eximm_q, eximm_d, expc_q, expc_d;

    logic        src_valid;
    logic [15:0] src_instr;
    logic [7:0]  src_pc;
    logic [3:0]  op;
    logic        is_alu, is_ldi, is_ld, is_st;
    logic        is_beqz, is_jmp, is_halt;
    logic        use1, use2, byp1, byp2;
    logic        blocked, issue, writes_rd, to_ex, redirect;
    logic [7:0]  opa, opb;

    // Source selection: a held instruction always takes priority over fetch.
    always_comb begin
        src_valid = 1'b0;
        src_instr = if_instruction;
        src_pc    = if_pc;
        case (state_q)
            S_HOLD: begin
                src_valid = 1'b1;
                src_instr = hold_instr_q;
                src_pc    = hold_pc_q;
            end
            S_RUN:   src_valid = if_valid;
            default: src_valid = 1'b0;
        endcase
    end

    assign op      = src_instr[15:12];
    assign is_alu  = ~op[3];
    assign is_ldi  = (op == 4'h8);
    assign is_ld   = (op == 4'h9);
    assign is_st   = (op == 4'hA);
    assign is_beqz = (op == 4'hB);
    assign is_jmp  = (op == 4'hC);
    assign is_halt = (op == 4'hF);

    assign use1 = src_valid & (is_alu | is_ld | is_st | is_beqz);
    assign use2 = src_valid & (is_alu | is_st);

    assign rf_raddr1 = ~use1 ? 3'd0 :
                       is_beqz ? src_instr[11:9] : src_instr[8:6];
    assign rf_raddr2 = ~use2 ? 3'd0 :
                       is_st ? src_instr[11:9] : src_instr[5:3];

`ifdef DECODE_WB_BYPASS_EN
    // A register being written back this cycle is forwarded, not waited on.
    assign byp1 = use1 & wb_valid & (wb_rd == rf_raddr1);
    assign byp2 = use2 & wb_valid & (wb_rd == rf_raddr2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign opa = byp1 ? wb_data : rf_rdata1;
    assign opb = byp2 ? wb_data : rf_rdata2;

    assign blocked = (use1 & sb_q[rf_raddr1] & ~byp1)
                   | (use2 & sb_q[rf_raddr2] & ~byp2);
    assign issue     = src_valid & ~blocked & ~reset;
    assign writes_rd = is_alu | is_ldi | is_ld;
    assign to_ex     = writes_rd | is_st;
    assign redirect  = issue & (is_jmp | (is_beqz & (opa == 8'h00)));

    assign PC_sel        = redirect;
    assign flush         = redirect;
    assign branch_target = ~redirect ? 8'h00 :
                           is_jmp ? src_instr[11:4] : src_instr[7:0];
    assign stall = ~reset & ((state_q == S_HALTED)
                           | (src_valid & blocked)
                           | (issue & is_halt));

    always_comb begin
        state_d      = state_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        case (state_q)
            S_RUN: begin
                if (src_valid & blocked) begin
                    state_d      = S_HOLD;
                    hold_instr_d = if_instruction;
                    hold_pc_d    = if_pc;
                end else if (issue & is_halt) begin
                    state_d = S_HALTED;
                end
            end
            S_HOLD: begin
                if (issue) state_d = is_halt ? S_HALTED : S_RUN;
            end
            default: state_d = state_q;
        endcase
    end

    // Set after clear so a same-cycle issue to the same register wins.
    always_comb begin
        sb_d = sb_q;
        if (wb_valid) sb_d[wb_rd] = 1'b0;
        if (issue & writes_rd) sb_d[src_instr[11:9]] = 1'b1;
    end

    always_comb begin
        halt_d  = halt_q | (issue & is_halt);
        exv_d   = issue & to_ex;
        exrw_d  = exrw_q;
        exmr_d  = exmr_q;
        exmw_d  = exmw_q;
        exop_d  = exop_q;
        exrd_d  = exrd_q;
        exa_d   = exa_q;
        exb_d   = exb_q;
        eximm_d = eximm_q;
        expc_d  = expc_q;
        if (exv_d) begin
            exrw_d  = writes_rd;
            exmr_d  = is_ld;
            exmw_d  = is_st;
            exop_d  = op;
            exrd_d  = src_instr[11:9];
            exa_d   = opa;
            exb_d   = opb;
            eximm_d = src_instr[7:0];
            expc_d  = src_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            hold_instr_q <= 16'h0000;
            hold_pc_q    <= 8'h00;
            sb_q         <= 8'h00;
            halt_q       <= 1'b0;
            exv_q        <= 1'b0;
            exrw_q       <= 1'b0;
            exmr_q       <= 1'b0;
            exmw_q       <= 1'b0;
            exop_q       <= 4'h0;
            exrd_q       <= 3'd0;
            exa_q        <= 8'h00;
            exb_q        <= 8'h00;
            eximm_q      <= 8'h00;
            expc_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            sb_q         <= sb_d;
            halt_q       <= halt_d;
            exv_q        <= exv_d;
            exrw_q       <= exrw_d;
            exmr_q       <= exmr_d;
            exmw_q       <= exmw_d;
            exop_q       <= exop_d;
            exrd_q       <= exrd_d;
            exa_q        <= exa_d;
            exb_q        <= exb_d;
            eximm_q      <= eximm_d;
            expc_q       <= expc_d;
        end
    end

    assign halt         = halt_q;
    assign ex_valid     = exv_q;
    assign ex_reg_write = exrw_q;
    assign ex_mem_read  = exmr_q;
    assign ex_mem_write = exmw_q;
    assign ex_opcode    = exop_q;
    assign ex_rd        = exrd_q;
    assign ex_a         = exa_q;
    assign ex_b         = exb_q;
    assign ex_imm       = eximm_q;
    assign ex_pc        = expc_q;

endmodule
